tt_mux_select_seq: RTL and testbench

Control-port sequencer that drives the TinyTapeout mux selection interface (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`) directly upstream of the chip's control pins. Given a design address, it performs the full select protocol:

- disable the currently enabled design;
- reset the mux address counter;
- issue exactly `addr` increment pulses;
- enable the selected design.

It replaces hand-sequenced firmware bit-banging in FPGA demo boards and in the mux verification bench.

---
 rtl/tt_mux_select_seq_pkg.sv | 7 +
 rtl/tt_mux_select_seq_if.sv | 13 +
 rtl/tt_mux_phase_timer.sv | 18 +
 rtl/tt_mux_select_seq.sv | 79 +++++++
 tb/tb_tt_mux_select_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tt_mux_select_seq_pkg.sv
// tt_mux_ctrl_pkg: sequencer state encoding and phase-timer width shared by the mux select block.
package tt_mux_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DIS, RST, GAP, INC_HI, INC_LO} mux_seq_state_t;
  localparam int HALF_CYC_MAX = 255;
  // Sized for the largest legal HALF_CYC so any instance fits.
  localparam int PHASE_W = $clog2(HALF_CYC_MAX + 1);
endpackage

// File: rtl/tt_mux_select_seq_if.sv
// tt_mux_select_seq_if: request/status handshake plus the three mux control pins.
interface tt_mux_select_seq_if #(parameter int ADDR_W = 10);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  modport master (output start, addr, input busy, done, cur_addr, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena);
  modport slave (input start, addr, output busy, done, cur_addr, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena);
endinterface

// File: rtl/tt_mux_phase_timer.sv
// tt_mux_phase_timer: loadable down-counter timing each protocol phase; expire flags the last cycle.
module tt_mux_phase_timer
  import tt_mux_ctrl_pkg::*;
#(
  parameter int HALF_CYC = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  output logic expire_o
);
  logic [PHASE_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (load_i) cnt_q <= PHASE_W'(HALF_CYC - 1);
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign expire_o = cnt_q == '0;
endmodule

// File: rtl/tt_mux_select_seq.sv
// tt_mux_select_seq: drives disable / counter reset / N increments / enable on the TinyTapeout mux pins.
module tt_mux_select_seq
  import tt_mux_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int HALF_CYC = 4
) (
  input logic clk,
  input logic reset_n,
  tt_mux_select_seq_if.slave bus
);
  mux_seq_state_t    state_q;
  logic [ADDR_W-1:0] remain_q, cur_addr_q;
  logic              busy_q, done_q, rst_n_q, inc_q, ena_q;
  logic              expire, accept_d, load_d;
  // A start coinciding with the done pulse is dropped: the sequence it overlaps is still finishing.
  assign accept_d = state_q == IDLE && bus.start && !done_q;
  assign load_d   = accept_d || (state_q != IDLE && expire);
  tt_mux_phase_timer #(.HALF_CYC(HALF_CYC)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (load_d),
    .expire_o (expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      cur_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rst_n_q    <= 1'b1;
      inc_q      <= 1'b0;
      ena_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept_d) begin
          state_q  <= DIS;
          remain_q <= bus.addr;
          busy_q   <= 1'b1;
          ena_q    <= 1'b0;
        end
        DIS: if (expire) begin
          state_q    <= RST;
          rst_n_q    <= 1'b0;
          cur_addr_q <= '0;
        end
        RST: if (expire) begin
          state_q <= GAP;
          rst_n_q <= 1'b1;
        end
        GAP, INC_LO: if (expire) begin
          if (remain_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ena_q   <= 1'b1;
          end else begin
            state_q    <= INC_HI;
            inc_q      <= 1'b1;
            cur_addr_q <= cur_addr_q + 1'b1;
            remain_q   <= remain_q - 1'b1;
          end
        end
        INC_HI: if (expire) begin
          state_q <= INC_LO;
          inc_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cur_addr       = cur_addr_q;
  assign bus.ctrl_sel_rst_n = rst_n_q;
  assign bus.ctrl_sel_inc   = inc_q;
  assign bus.ctrl_ena       = ena_q;
endmodule

// File: tb/tb_tt_mux_select_seq.sv
// tb_tt_mux_select_seq: directed checks of the select sequencer at HALF_CYC=1 (dut_a) and HALF_CYC=4 (dut_b).
module tb_tt_mux_select_seq;
  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int r_dt, r_np, r_hi, r_first_inc, r_rst_first, r_rst_cnt, r_ca, r_viol, r_ena1, r_busy1, r_ena_done, r_busy_done, r_busy_after;
  bit found;
  always #5 clk = ~clk;
  tt_mux_select_seq_if #(.ADDR_W(10)) a_if ();
  tt_mux_select_seq_if #(.ADDR_W(10)) b_if ();
  tt_mux_select_seq #(.ADDR_W(10), .HALF_CYC(1)) dut_a (.clk(clk), .reset_n(rst_a_n), .bus(a_if.slave));
  tt_mux_select_seq #(.ADDR_W(10), .HALF_CYC(4)) dut_b (.clk(clk), .reset_n(rst_b_n), .bus(b_if.slave));
  // Behavioural mux on dut_a's pins: design i drives uo_out = 3*i+1.
  logic [9:0] mux_cnt;
  always @(posedge a_if.ctrl_sel_inc or negedge a_if.ctrl_sel_rst_n)
    if (!a_if.ctrl_sel_rst_n) mux_cnt <= '0;
    else mux_cnt <= mux_cnt + 1'b1;
  wire [7:0] mux_uo = a_if.ctrl_ena ? 8'(mux_cnt * 10'd3 + 10'd1) : 8'h00;
  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_in(input bit b, input bit s, input int a);
    if (b) begin
      b_if.start = s;
      b_if.addr  = 10'(a);
    end else begin
      a_if.start = s;
      a_if.addr  = 10'(a);
    end
  endtask
  // Launch one sequence and observe it cycle by cycle (t = cycles after the accepting edge).
  task automatic run(input bit b, input int a, input bit poke);
    logic inc, rn, prev;
    set_in(b, 1'b1, a);
    step();
    set_in(b, 1'b0, 7);
    r_dt = -1; r_np = 0; r_hi = 0; r_first_inc = -1; r_rst_first = -1; r_rst_cnt = 0; r_ca = -1;
    prev = 1'b0;
    for (int t = 1; t <= 4000; t++) begin
      inc = b ? b_if.ctrl_sel_inc : a_if.ctrl_sel_inc;
      rn  = b ? b_if.ctrl_sel_rst_n : a_if.ctrl_sel_rst_n;
      if (t == 1) begin
        r_ena1  = int'(b ? b_if.ctrl_ena : a_if.ctrl_ena);
        r_busy1 = int'(b ? b_if.busy : a_if.busy);
      end
      if (inc && !rn) r_viol++;
      if (!rn) begin
        r_rst_cnt++;
        if (r_rst_first < 0) r_rst_first = t;
      end
      if (inc) begin
        r_hi++;
        if (!prev) begin
          r_np++;
          if (r_first_inc < 0) r_first_inc = t;
        end
      end
      prev = inc;
      if (b ? b_if.done : a_if.done) begin
        r_dt        = t;
        r_ca        = int'(b ? b_if.cur_addr : a_if.cur_addr);
        r_ena_done  = int'(b ? b_if.ctrl_ena : a_if.ctrl_ena);
        r_busy_done = int'(b ? b_if.busy : a_if.busy);
        break;
      end
      set_in(b, poke && t == 2, 7);
      step();
    end
    set_in(b, poke, 7);
    step();
    set_in(b, 1'b0, 7);
    r_busy_after = int'(b ? b_if.busy : a_if.busy);
  endtask
  initial begin
    r_viol = 0;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_done", int'(a_if.done), 0);
    chk("rst_cur_addr", int'(a_if.cur_addr), 0);
    chk("rst_sel_rst_n", int'(a_if.ctrl_sel_rst_n), 1);
    chk("rst_sel_inc", int'(a_if.ctrl_sel_inc), 0);
    chk("rst_ena", int'(a_if.ctrl_ena), 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step();
    run(0, 0, 0);
    chk("h1a0_busy_n1", r_busy1, 1);
    chk("h1a0_ena_n1", r_ena1, 0);
    chk("h1a0_rst_first", r_rst_first, 2);
    chk("h1a0_rst_len", r_rst_cnt, 1);
    chk("h1a0_pulses", r_np, 0);
    chk("h1a0_done_t", r_dt, 4);
    chk("h1a0_ena_done", r_ena_done, 1);
    chk("h1a0_busy_done", r_busy_done, 0);
    chk("h1a0_ena_hold", int'(a_if.ctrl_ena), 1);
    run(0, 1, 0);
    chk("h1a1_ena_falls", r_ena1, 0);
    chk("h1a1_first_inc", r_first_inc, 4);
    chk("h1a1_done_t", r_dt, 6);
    chk("h1a1_cur_addr", r_ca, 1);
    run(1, 5, 0);
    chk("h4a5_pulses", r_np, 5);
    chk("h4a5_hi_cycles", r_hi, 20);
    chk("h4a5_first_inc", r_first_inc, 13);
    chk("h4a5_rst_first", r_rst_first, 5);
    chk("h4a5_rst_len", r_rst_cnt, 4);
    chk("h4a5_done_t", r_dt, 53);
    chk("h4a5_cur_addr", r_ca, 5);
    run(0, 1023, 0);
    chk("h1a1023_pulses", r_np, 1023);
    chk("h1a1023_cur_addr", r_ca, 1023);
    chk("h1a1023_done_t", r_dt, 2050);
    run(0, 3, 1);
    chk("restart_pulses", r_np, 3);
    chk("restart_cur_addr", r_ca, 3);
    chk("restart_done_t", r_dt, 10);
    chk("done_cycle_start_ignored", r_busy_after, 0);
    step();
    chk("no_queued_start", int'(a_if.busy), 0);
    set_in(1, 1'b1, 5);
    step();
    set_in(1, 1'b0, 5);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      if (b_if.ctrl_sel_inc) found = 1'b1;
      else step();
    end
    chk("arst_reached_inc_hi", int'(found), 1);
    rst_b_n = 1'b0;
    #1;
    chk("arst_sel_inc", int'(b_if.ctrl_sel_inc), 0);
    chk("arst_sel_rst_n", int'(b_if.ctrl_sel_rst_n), 1);
    chk("arst_ena", int'(b_if.ctrl_ena), 0);
    chk("arst_busy", int'(b_if.busy), 0);
    chk("arst_cur_addr", int'(b_if.cur_addr), 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    step();
    run(1, 2, 0);
    chk("post_rst_done_t", r_dt, 29);
    chk("post_rst_pulses", r_np, 2);
    chk("post_rst_cur_addr", r_ca, 2);
    run(0, 2, 0);
    chk("mux_done_t", r_dt, 8);
    chk("mux_sel_addr", int'(mux_cnt), 2);
    chk("mux_uo_out", int'(mux_uo), 7);
    chk("inc_while_rst_low", r_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
